// File: rtl/lcd_pkg.sv
// Shared types, constants and helpers for the LCD instruction path.
package lcd_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWaitDone = 2'd2,
        StGap      = 2'd3
    } arb_state_e;

    localparam logic [9:0] LCD_CLEAR = 10'h001;
    localparam logic [9:0] LCD_HOME  = 10'h002;

    localparam int unsigned GAP_CNT_W               = 17;
    localparam int unsigned DEFAULT_GAP_CYCLES      = 2000;
    localparam int unsigned DEFAULT_LONG_GAP_CYCLES = 82000;

    // Clear display (0x001) and return home (0x002/0x003) need the long execution gap.
    // Only bit 0 is a don't-care for home, so matching word[9:1] against both codes covers
    // 0x000..0x003; the unused 0x000 falls on the safe (longer) side.
    function automatic logic is_long_instr(input logic [9:0] word);
        return (word[9:1] == LCD_CLEAR[9:1]) || (word[9:1] == LCD_HOME[9:1]);
    endfunction

endpackage

// File: rtl/lcd_gap_timer.sv
// Down-counter used to enforce LCD execution gaps; loads a value and counts to zero.
module lcd_gap_timer
    import lcd_pkg::*;
#(
    parameter int unsigned CNT_W = GAP_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_instr_arbiter.sv
// Round-robin arbiter with burst locking in front of the single LCD instruction transmitter.
module lcd_instr_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned GAP_CYCLES      = DEFAULT_GAP_CYCLES,
    parameter int unsigned LONG_GAP_CYCLES = DEFAULT_LONG_GAP_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [10*NUM_REQ-1:0] req_db,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [9:0]           tx_db,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [1:0]           owner
);

    localparam logic [GAP_CNT_W-1:0] GapLoad     = GAP_CNT_W'(GAP_CYCLES - 1);
    localparam logic [GAP_CNT_W-1:0] LongGapLoad = GAP_CNT_W'(LONG_GAP_CYCLES - 1);

    arb_state_e state_q, state_d;
    logic [9:0] tx_db_q, tx_db_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] rr_q, rr_d;
    logic       last_q, last_d;
    logic       long_q, long_d;
    logic       lock_q, lock_d;

    logic       grant_vld;
    logic [1:0] grant_idx;
    logic [9:0] grant_word;
    logic       grant_last;

    logic                 gap_load;
    logic [GAP_CNT_W-1:0] gap_value;
    logic                 gap_zero;

    lcd_gap_timer #(
        .CNT_W (GAP_CNT_W)
    ) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .load  (gap_load),
        .value (gap_value),
        .zero  (gap_zero)
    );

    // Pick the requester to serve: locked owner only, else first valid at/after rr pointer.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (lock_q) begin
            grant_idx = owner_q;
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                if (2'(k) == owner_q) grant_vld = req_valid[k];
            end
        end else begin
            // First pass covers pointer..top, second pass wraps to the bottom.
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                if (!grant_vld && req_valid[k] && (k >= int'(rr_q))) begin
                    grant_vld = 1'b1;
                    grant_idx = 2'(k);
                end
            end
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                if (!grant_vld && req_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = 2'(k);
                end
            end
        end
    end

    // Mux the granted requester's word and last flag.
    always_comb begin
        grant_word = '0;
        grant_last = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (2'(k) == grant_idx) begin
                grant_word = req_db[10*k +: 10];
                grant_last = req_last[k];
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        tx_db_d   = tx_db_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        last_d    = last_q;
        long_d    = long_q;
        lock_d    = lock_q;
        gap_load  = 1'b0;
        gap_value = '0;
        req_ready = '0;

        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    // Gate with reset so the pulse never shows while held in reset.
                    for (int k = 0; k < int'(NUM_REQ); k++) begin
                        req_ready[k] = (2'(k) == grant_idx) && !reset;
                    end
                    tx_db_d = grant_word;
                    owner_d = grant_idx;
                    last_d  = grant_last;
                    long_d  = is_long_instr(grant_word);
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (tx_done) begin
                    gap_load  = 1'b1;
                    gap_value = long_q ? LongGapLoad : GapLoad;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (gap_zero) begin
                    state_d = StIdle;
                    lock_d  = !last_q;
                    if (last_q) begin
                        rr_d = (int'(owner_q) + 1 >= int'(NUM_REQ)) ? 2'd0 : owner_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and captured-transaction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tx_db_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            last_q  <= 1'b0;
            long_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_db_q <= tx_db_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            last_q  <= last_d;
            long_q  <= long_d;
            lock_q  <= lock_d;
        end
    end

    assign tx_start = (state_q == StIssue);
    assign busy     = (state_q != StIdle);
    assign tx_db    = tx_db_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_lcd_instr_arbiter.sv
// Self-checking bench: requesters and transmitter modelled as queues, arbiter checked
// cycle by cycle against a transaction-level reference model.
module tb_lcd_instr_arbiter;

    localparam int NR   = 3;
    localparam int GAP  = 12;
    localparam int LONG = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [10*NR-1:0]  req_db;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              tx_start;
    logic [9:0]        tx_db;
    logic              tx_done;
    logic              busy;
    logic [1:0]        owner;

    lcd_instr_arbiter #(
        .NUM_REQ         (NR),
        .GAP_CYCLES      (GAP),
        .LONG_GAP_CYCLES (LONG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_db    (req_db),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_db     (tx_db),
        .tx_done   (tx_done),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-requester pending words: {last, word}.
    logic [10:0] rq [NR][$];

    // Reference model state.
    int         m_rr, m_owner, m_issue_cyc, m_free_at, done_due, pop_idx;
    bit         m_lock, m_inflight, m_last;
    logic [9:0] m_word;

    bit spurious_en, drop_en;
    int lat_lo = 1;
    int lat_hi = 4;

    int   grant_log[$];
    int   grant_cyc[$];
    int   obs_start[$];
    int   obs_done[$];
    int   busy_fall;
    logic prev_busy;

    function automatic int model_pick(input logic [NR-1:0] v);
        if (m_lock) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NR; k++) begin
            if (v[(m_rr + k) % NR]) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    task automatic clear_logs();
        grant_log.delete();
        grant_cyc.delete();
        obs_start.delete();
        obs_done.delete();
        busy_fall = -1;
    endtask

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_owner = 0; m_inflight = 0; m_free_at = 0;
        pop_idx = -1; prev_busy = 1'b0; done_due = -1; m_issue_cyc = -1;
    endtask

    // One clock cycle: update stimulus, then check every output against the model.
    task automatic step();
        logic [NR-1:0] exp_ready;
        bit            exp_busy, exp_start, lng;
        int            g;
        @(negedge clk);
        cyc++;
        if (pop_idx >= 0) begin
            void'(rq[pop_idx].pop_front());
            pop_idx = -1;
        end
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (rq[i].size() != 0) && !(drop_en && $urandom_range(0, 3) == 0);
            if (req_valid[i]) begin
                req_db[10*i +: 10] = rq[i][0][9:0];
                req_last[i]        = rq[i][0][10];
            end else begin
                req_db[10*i +: 10] = 10'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
        tx_done = (m_inflight && cyc == done_due) ||
                  (spurious_en && !m_inflight && $urandom_range(0, 2) == 0);
        #1;
        exp_busy  = m_inflight || (cyc < m_free_at);
        exp_start = m_inflight && (cyc == m_issue_cyc);
        exp_ready = '0;
        if (!exp_busy) begin
            g = model_pick(req_valid);
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                m_inflight   = 1;
                m_issue_cyc  = cyc + 1;
                m_word       = rq[g][0][9:0];
                m_last       = rq[g][0][10];
                m_owner      = g;
                done_due     = cyc + 1 + $urandom_range(lat_lo, lat_hi);
                pop_idx      = g;
                grant_log.push_back(g);
                grant_cyc.push_back(cyc);
            end
        end
        total++;
        if (req_ready !== exp_ready) begin
            bad++;
            $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready);
        end
        total++;
        if (tx_start !== exp_start) begin
            bad++;
            $display("FAIL tx_start cyc=%0d got=%b want=%b", cyc, tx_start, exp_start);
        end
        total++;
        if (busy !== exp_busy) begin
            bad++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
        end
        if (exp_busy) begin
            total++;
            if (owner !== 2'(m_owner)) begin
                bad++;
                $display("FAIL owner cyc=%0d got=%0d want=%0d", cyc, owner, m_owner);
            end
            total++;
            if (tx_db !== m_word) begin
                bad++;
                $display("FAIL tx_db cyc=%0d got=%h want=%h", cyc, tx_db, m_word);
            end
        end
        if (tx_start === 1'b1) obs_start.push_back(cyc);
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
        prev_busy = busy;
        if (m_inflight && cyc == done_due) begin
            lng        = (m_word < 10'd4);
            m_inflight = 0;
            m_free_at  = cyc + (lng ? LONG : GAP) + 1;
            m_lock     = !m_last;
            if (m_last) m_rr = (m_owner + 1) % NR;
            obs_done.push_back(cyc);
        end
    endtask

    task automatic drain(input int budget);
        int  n = 0;
        bit  pend;
        do begin
            pend = m_inflight || (cyc < m_free_at);
            for (int i = 0; i < NR; i++) if (rq[i].size() != 0) pend = 1;
            if (pend) begin
                step();
                n++;
            end
        end while (pend && n < budget);
        if (pend) begin
            total++;
            bad++;
            $display("FAIL drain timeout cyc=%0d got=busy want=idle", cyc);
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        tx_done   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < NR; i++) rq[i].delete();
    endtask

    task automatic test_reset();
        req_valid = '0; req_db = '0; req_last = '0; tx_done = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        cyc++;
        #1;
        total++; if (req_ready !== '0)  begin bad++; $display("FAIL rst_ready got=%b want=0", req_ready); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b want=0", tx_start); end
        total++; if (tx_db !== 10'h000) begin bad++; $display("FAIL rst_db got=%h want=000", tx_db); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (owner !== 2'd0)    begin bad++; $display("FAIL rst_owner got=%0d want=0", owner); end
        apply_reset();
        repeat (4) step();
    endtask

    task automatic test_single();
        clear_logs();
        rq[0].push_back({1'b1, 10'h028});
        drain(500);
        total++;
        if (grant_log.size() != 1 || obs_start.size() != 1 || obs_done.size() != 1) begin
            bad++;
            $display("FAIL single_count got=%0d/%0d want=1/1", grant_log.size(), obs_start.size());
        end else begin
            total++;
            if (obs_start[0] - grant_cyc[0] != 1) begin
                bad++;
                $display("FAIL single_latency got=%0d want=1", obs_start[0] - grant_cyc[0]);
            end
            total++;
            if (busy_fall - obs_done[0] != GAP + 1) begin
                bad++;
                $display("FAIL single_gap got=%0d want=%0d", busy_fall - obs_done[0], GAP + 1);
            end
        end
    endtask

    task automatic test_long_gap();
        clear_logs();
        rq[1].push_back({1'b1, 10'h001});
        rq[1].push_back({1'b1, 10'h028});
        drain(1000);
        total++;
        if (obs_start.size() != 2 || obs_done.size() != 2) begin
            bad++;
            $display("FAIL long_count got=%0d want=2", obs_start.size());
        end else begin
            total++;
            if (obs_start[1] - obs_done[0] != LONG + 2) begin
                bad++;
                $display("FAIL long_gap got=%0d want=%0d", obs_start[1] - obs_done[0], LONG + 2);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_order[4] = '{0, 1, 0, 1};
        apply_reset();
        clear_logs();
        for (int n = 0; n < 2; n++) begin
            rq[0].push_back({1'b1, 10'($urandom_range(4, 1023))});
            rq[1].push_back({1'b1, 10'($urandom_range(4, 1023))});
        end
        drain(1000);
        total++;
        if (grant_log.size() != 4) begin
            bad++;
            $display("FAIL rr_count got=%0d want=4", grant_log.size());
        end else begin
            for (int n = 0; n < 4; n++) begin
                total++;
                if (grant_log[n] != exp_order[n]) begin
                    bad++;
                    $display("FAIL rr_order[%0d] got=%0d want=%0d", n, grant_log[n], exp_order[n]);
                end
            end
        end
    endtask

    task automatic test_burst_lock();
        int first_other;
        apply_reset();
        clear_logs();
        rq[0].push_back({1'b0, 10'h080});
        for (int n = 0; n < 16; n++) begin
            rq[0].push_back({(n == 15), 2'b10, 8'($urandom_range(8'h20, 8'h7e))});
        end
        rq[1].push_back({1'b1, 10'h0c0});
        rq[1].push_back({1'b1, 10'h241});
        drain(3000);
        first_other = -1;
        foreach (grant_log[n]) if (first_other < 0 && grant_log[n] != 0) first_other = n;
        total++;
        if (first_other != 17) begin
            bad++;
            $display("FAIL burst_first_req1 got=%0d want=17", first_other);
        end
        total++;
        if (grant_log.size() != 19) begin
            bad++;
            $display("FAIL burst_count got=%0d want=19", grant_log.size());
        end
    endtask

    task automatic test_spurious_random();
        int words = 0;
        clear_logs();
        spurious_en = 1;
        drop_en     = 1;
        for (int i = 0; i < NR; i++) begin
            int n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                logic [9:0] w;
                w = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 3)) : 10'($urandom);
                rq[i].push_back({(j == n - 1) || ($urandom_range(0, 1) == 1), w});
                words++;
            end
        end
        drain(5000);
        repeat (10) step();
        spurious_en = 0;
        drop_en     = 0;
        total++;
        if (obs_start.size() != words) begin
            bad++;
            $display("FAIL spur_starts got=%0d want=%0d", obs_start.size(), words);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        apply_reset();
        rq[0].push_back({1'b1, 10'h028});
        drain(500);
        clear_logs();
        lat_lo = 6;
        lat_hi = 6;
        rq[1].push_back({1'b1, 10'h031});
        while (!(m_inflight && cyc > m_issue_cyc) && n < 50) begin
            step();
            n++;
        end
        total++;
        if (!(m_inflight && cyc > m_issue_cyc)) begin
            bad++;
            $display("FAIL rmid_reach got=0 want=1");
        end
        total++;
        if (grant_log.size() != 1 || grant_log[0] != 1) begin
            bad++;
            $display("FAIL rmid_pre_grant got=%0d want=1", grant_log.size() ? grant_log[0] : -1);
        end
        reset     = 1'b1;
        tx_done   = 1'b0;
        req_valid = 3'b011;
        @(negedge clk);
        cyc++;
        #1;
        total++; if (req_ready !== '0)  begin bad++; $display("FAIL rmid_ready got=%b want=0", req_ready); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rmid_start got=%b want=0", tx_start); end
        total++; if (tx_db !== 10'h000) begin bad++; $display("FAIL rmid_db got=%h want=000", tx_db); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        total++; if (owner !== 2'd0)    begin bad++; $display("FAIL rmid_owner got=%0d want=0", owner); end
        req_valid = '0;
        reset     = 1'b0;
        model_reset();
        for (int i = 0; i < NR; i++) rq[i].delete();
        lat_lo = 1;
        lat_hi = 4;
        clear_logs();
        rq[1].push_back({1'b1, 10'h045});
        rq[0].push_back({1'b1, 10'h046});
        drain(500);
        total++;
        if (grant_log.size() != 2 || grant_log[0] != 0) begin
            bad++;
            $display("FAIL rmid_rearb got=%0d want=0", grant_log.size() ? grant_log[0] : -1);
        end
    endtask

    initial begin
        model_reset();
        spurious_en = 0;
        drop_en     = 0;
        clear_logs();
        test_reset();
        test_single();
        test_long_gap();
        test_round_robin();
        test_burst_lock();
        test_spurious_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
